// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the store-buffer / LSU dcache arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY, RESP)
//   arb_owner_e : owner of the in-flight dcache request (load or store)
//   WORD_OFFSET : number of byte-offset bits below the word address
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_LOAD,
    OWN_STORE
  } arb_owner_e;

  localparam int unsigned WORD_OFFSET = 2;

endpackage

// File: rtl/arb_grant_sel.sv
// arb_grant_sel: purely combinational winner selection between the head store
// of the store buffer and the pending LSU load.
// Ports:
//   stb_req_i     : store request present
//   lsu_req_i     : load request present
//   stb_full_i    : store buffer full
//   stb_word_i    : head store word address
//   lsu_word_i    : load word address
//   starve_i      : store has waited too many load grants (tied low when unused)
//   grant_valid_o : some request is present
//   grant_owner_o : winner (OWN_STORE or OWN_LOAD), meaningful when grant_valid_o
module arb_grant_sel
  import arb_pkg::*;
#(
  parameter int unsigned WORD_W = 30
) (
  input  logic              stb_req_i,
  input  logic              lsu_req_i,
  input  logic              stb_full_i,
  input  logic [WORD_W-1:0] stb_word_i,
  input  logic [WORD_W-1:0] lsu_word_i,
  input  logic              starve_i,
  output logic              grant_valid_o,
  output arb_owner_e        grant_owner_o
);

  assign grant_valid_o = stb_req_i | lsu_req_i;

  always_comb begin
    grant_owner_o = OWN_LOAD;
    if (stb_req_i && !lsu_req_i) begin
      grant_owner_o = OWN_STORE;
    end else if (stb_req_i && lsu_req_i) begin
      // Loads bypass the buffered store unless the buffer is full, the store
      // has been starved, or the load reads the word the head store writes.
      if (starve_i || stb_full_i || (stb_word_i == lsu_word_i)) begin
        grant_owner_o = OWN_STORE;
      end
    end
  end

endmodule

// File: rtl/stb_dcache_arbiter.sv
// stb_dcache_arbiter: arbitrates store-buffer drain writes against LSU loads
// onto the single dcache request port; one registered request in flight.
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   stb2arb_* / arb2stb_ack   : head store request and its completion ack
//   lsu2arb_* / arb2lsu_*     : load request, completion ack and read data
//   arb2dcache_*              : registered request to the dcache
//   dcache2arb_rdata/_ack     : dcache read data and transaction-done
// Optional feature macro: ARB_STARVE_GUARD_EN -- when defined, a store that
// has watched STARVE_MAX consecutive load grants wins the next arbitration.
module stb_dcache_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_SEL_WIDTH = 4,
  parameter int unsigned STARVE_MAX     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     stb2arb_addr,
  input  logic [DATA_WIDTH-1:0]     stb2arb_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte,
  input  logic                      stb2arb_req,
  input  logic                      stb2arb_full,
  input  logic                      stb2arb_dmem_sel,
  output logic                      arb2stb_ack,
  input  logic [ADDR_WIDTH-1:0]     lsu2arb_addr,
  input  logic [BYTE_SEL_WIDTH-1:0] lsu2arb_sel_byte,
  input  logic                      lsu2arb_req,
  input  logic                      lsu2arb_dmem_sel,
  output logic [DATA_WIDTH-1:0]     arb2lsu_rdata,
  output logic                      arb2lsu_ack,
  output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
  output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
  output logic                      arb2dcache_w_en,
  output logic                      arb2dcache_req,
  output logic                      arb2dcache_dmem_sel,
  input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata,
  input  logic                      dcache2arb_ack
);

  arb_state_e                state_q, state_d;
  arb_owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [BYTE_SEL_WIDTH-1:0] sel_q, sel_d;
  logic                      w_en_q, w_en_d;
  logic                      req_q, req_d;
  logic                      dmem_q, dmem_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  logic       grant_valid;
  arb_owner_e grant_owner;
  logic       starve;

  if (STARVE_MAX == 0) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve = (starve_cnt_q == CNT_W'(STARVE_MAX));

  // Counts load grants that overtook a waiting store; only evaluated in IDLE
  // since that is the only state where grants are made.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (!stb2arb_req || (grant_valid && grant_owner == OWN_STORE)) begin
        starve_cnt_d = '0;
      end else if (grant_valid) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  arb_grant_sel #(
    .WORD_W(ADDR_WIDTH - WORD_OFFSET)
  ) u_grant_sel (
    .stb_req_i    (stb2arb_req),
    .lsu_req_i    (lsu2arb_req),
    .stb_full_i   (stb2arb_full),
    .stb_word_i   (stb2arb_addr[ADDR_WIDTH-1:WORD_OFFSET]),
    .lsu_word_i   (lsu2arb_addr[ADDR_WIDTH-1:WORD_OFFSET]),
    .starve_i     (starve),
    .grant_valid_o(grant_valid),
    .grant_owner_o(grant_owner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    w_en_d  = w_en_q;
    req_d   = req_q;
    dmem_d  = dmem_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = BUSY;
          owner_d = grant_owner;
          req_d   = 1'b1;
          if (grant_owner == OWN_STORE) begin
            addr_d  = stb2arb_addr;
            wdata_d = stb2arb_wdata;
            sel_d   = stb2arb_sel_byte;
            w_en_d  = 1'b1;
            dmem_d  = stb2arb_dmem_sel;
          end else begin
            addr_d  = lsu2arb_addr;
            wdata_d = '0;
            sel_d   = lsu2arb_sel_byte;
            w_en_d  = 1'b0;
            dmem_d  = lsu2arb_dmem_sel;
          end
        end
      end
      BUSY: begin
        if (dcache2arb_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          if (owner_q == OWN_LOAD) begin
            rdata_d = dcache2arb_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_LOAD;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      w_en_q  <= 1'b0;
      req_q   <= 1'b0;
      dmem_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      w_en_q  <= w_en_d;
      req_q   <= req_d;
      dmem_q  <= dmem_d;
      rdata_q <= rdata_d;
    end
  end

  // Acks are a one-cycle pulse: RESP always lasts exactly one cycle.
  assign arb2stb_ack         = (state_q == RESP) && (owner_q == OWN_STORE);
  assign arb2lsu_ack         = (state_q == RESP) && (owner_q == OWN_LOAD);
  assign arb2lsu_rdata       = rdata_q;
  assign arb2dcache_addr     = addr_q;
  assign arb2dcache_wdata    = wdata_q;
  assign arb2dcache_sel_byte = sel_q;
  assign arb2dcache_w_en     = w_en_q;
  assign arb2dcache_req      = req_q;
  assign arb2dcache_dmem_sel = dmem_q;

endmodule

// File: tb/tb_stb_dcache_arbiter.sv
// tb_stb_dcache_arbiter: self-checking bench for stb_dcache_arbiter.
// Requesters and the dcache responder are driven from one process; a
// rule-level reference model predicts each grant and each ack pulse.
// Honours ARB_STARVE_GUARD_EN for the starvation expectations.
module tb_stb_dcache_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] stb2arb_addr, stb2arb_wdata;
  logic [3:0]  stb2arb_sel_byte;
  logic        stb2arb_req, stb2arb_full, stb2arb_dmem_sel;
  logic        arb2stb_ack;
  logic [31:0] lsu2arb_addr;
  logic [3:0]  lsu2arb_sel_byte;
  logic        lsu2arb_req, lsu2arb_dmem_sel;
  logic [31:0] arb2lsu_rdata;
  logic        arb2lsu_ack;
  logic [31:0] arb2dcache_addr, arb2dcache_wdata;
  logic [3:0]  arb2dcache_sel_byte;
  logic        arb2dcache_w_en, arb2dcache_req, arb2dcache_dmem_sel;
  logic [31:0] dcache2arb_rdata;
  logic        dcache2arb_ack;

  stb_dcache_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_SEL_WIDTH(4), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stb2arb_addr(stb2arb_addr), .stb2arb_wdata(stb2arb_wdata),
    .stb2arb_sel_byte(stb2arb_sel_byte), .stb2arb_req(stb2arb_req),
    .stb2arb_full(stb2arb_full), .stb2arb_dmem_sel(stb2arb_dmem_sel),
    .arb2stb_ack(arb2stb_ack),
    .lsu2arb_addr(lsu2arb_addr), .lsu2arb_sel_byte(lsu2arb_sel_byte),
    .lsu2arb_req(lsu2arb_req), .lsu2arb_dmem_sel(lsu2arb_dmem_sel),
    .arb2lsu_rdata(arb2lsu_rdata), .arb2lsu_ack(arb2lsu_ack),
    .arb2dcache_addr(arb2dcache_addr), .arb2dcache_wdata(arb2dcache_wdata),
    .arb2dcache_sel_byte(arb2dcache_sel_byte), .arb2dcache_w_en(arb2dcache_w_en),
    .arb2dcache_req(arb2dcache_req), .arb2dcache_dmem_sel(arb2dcache_dmem_sel),
    .dcache2arb_rdata(dcache2arb_rdata), .dcache2arb_ack(dcache2arb_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        full;
    logic        dmem;
  } st_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        dmem;
  } ld_t;

  typedef struct {
    bit          s_v;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_sel;
    logic        s_full;
    bit          l_v;
    logic [31:0] l_addr;
    logic [3:0]  l_sel;
    int          delay;
    logic [31:0] rdata;
    bit          exp_first_store;
    int          exp_n;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  st_t st_q[$];
  ld_t ld_q[$];
  bit  grant_log[$];

  // Reference model state: protocol phase of the single outstanding request,
  // the granted request, and the count of loads that overtook a waiting store.
  int          m_phase;   // 0 free, 1 request outstanding, 2 ack cycle
  int          m_starve;
  bit          m_store;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_sel;
  logic        m_dmem;
  int          dc_delay;
  int          dc_cnt;
  bit          fixed_rdata_en;
  logic [31:0] fixed_rdata;
  logic [31:0] exp_rdata;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endfunction

  task automatic drive_inputs();
    if (st_q.size() > 0) begin
      stb2arb_req      = 1'b1;
      stb2arb_addr     = st_q[0].addr;
      stb2arb_wdata    = st_q[0].wdata;
      stb2arb_sel_byte = st_q[0].sel;
      stb2arb_full     = st_q[0].full;
      stb2arb_dmem_sel = st_q[0].dmem;
    end else begin
      stb2arb_req = 1'b0;
      stb2arb_full = 1'b0;
    end
    if (ld_q.size() > 0) begin
      lsu2arb_req      = 1'b1;
      lsu2arb_addr     = ld_q[0].addr;
      lsu2arb_sel_byte = ld_q[0].sel;
      lsu2arb_dmem_sel = ld_q[0].dmem;
    end else begin
      lsu2arb_req = 1'b0;
    end
  endtask

  // Priority rules applied to the request values presented at the edge.
  function automatic bit model_pick_store();
    if (!lsu2arb_req) return 1'b1;
    if (!stb2arb_req) return 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    if (m_starve >= STARVE_MAX) return 1'b1;
`endif
    if (stb2arb_full) return 1'b1;
    if ((lsu2arb_addr / 4) == (stb2arb_addr / 4)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_engine(input int max_cycles);
    int cyc;
    bit dc_ack_edge;
    bit s;
    cyc = 0;
    drive_inputs();
    while ((st_q.size() > 0 || ld_q.size() > 0 || m_phase != 0) && cyc < max_cycles) begin
      @(posedge clk);
      #1;
      cyc++;
      dc_ack_edge = dcache2arb_ack;
      // owner ack: exactly the cycle after the dcache ack was sampled
      if (m_phase == 1 && dc_ack_edge) begin
        chk("stb_ack", arb2stb_ack, m_store);
        chk("lsu_ack", arb2lsu_ack, !m_store);
        if (!m_store) chk("lsu_rdata", arb2lsu_rdata, exp_rdata);
        n_txn++;
        $display("txn %0d: %s addr=0x%08h sel=0x%0h data=0x%08h", n_txn,
                 m_store ? "store" : "load ", m_addr, m_sel, m_store ? m_wdata : exp_rdata);
      end else begin
        chk("stb_ack_quiet", arb2stb_ack, 1'b0);
        chk("lsu_ack_quiet", arb2lsu_ack, 1'b0);
      end
      case (m_phase)
        0: begin
          if (stb2arb_req || lsu2arb_req) begin
            s       = model_pick_store();
            m_store = s;
            m_addr  = s ? stb2arb_addr : lsu2arb_addr;
            m_wdata = stb2arb_wdata;
            m_sel   = s ? stb2arb_sel_byte : lsu2arb_sel_byte;
            m_dmem  = s ? stb2arb_dmem_sel : lsu2arb_dmem_sel;
            chk("grant_req", arb2dcache_req, 1'b1);
            chk("grant_w_en", arb2dcache_w_en, s);
            chk("grant_addr", arb2dcache_addr, m_addr);
            chk("grant_sel", arb2dcache_sel_byte, m_sel);
            chk("grant_dmem", arb2dcache_dmem_sel, m_dmem);
            if (s) chk("grant_wdata", arb2dcache_wdata, m_wdata);
            grant_log.push_back(s);
            if (s || !stb2arb_req) m_starve = 0;
            else m_starve++;
            m_phase = 1;
            dc_cnt  = 0;
          end else begin
            chk("idle_req", arb2dcache_req, 1'b0);
            m_starve = 0;
          end
        end
        1: begin
          if (dc_ack_edge) begin
            chk("req_drop", arb2dcache_req, 1'b0);
            m_phase = 2;
          end else begin
            chk("busy_req", arb2dcache_req, 1'b1);
            chk("busy_addr", arb2dcache_addr, m_addr);
            chk("busy_w_en", arb2dcache_w_en, m_store);
            chk("busy_sel", arb2dcache_sel_byte, m_sel);
          end
        end
        default: begin
          chk("resp_req", arb2dcache_req, 1'b0);
          m_phase = 0;
        end
      endcase
      // requesters drop (or advance) on the ack they see
      if (arb2stb_ack && st_q.size() > 0) void'(st_q.pop_front());
      if (arb2lsu_ack && ld_q.size() > 0) void'(ld_q.pop_front());
      drive_inputs();
      // dcache responder: one-cycle ack after dc_delay busy cycles
      if (dcache2arb_ack) begin
        dcache2arb_ack = 1'b0;
      end else if (m_phase == 1) begin
        if (dc_cnt >= dc_delay) begin
          exp_rdata        = fixed_rdata_en ? fixed_rdata : $urandom;
          dcache2arb_rdata = exp_rdata;
          dcache2arb_ack   = 1'b1;
        end else begin
          dc_cnt++;
        end
      end
    end
    n_checks++;
    if (st_q.size() > 0 || ld_q.size() > 0 || m_phase != 0) begin
      n_fail++;
      $display("FAIL engine_timeout: %0d stores, %0d loads still pending after %0d cycles",
               st_q.size(), ld_q.size(), cyc);
      st_q.delete();
      ld_q.delete();
      m_phase = 0;
      dcache2arb_ack = 1'b0;
      drive_inputs();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req"}, arb2dcache_req, 1'b0);
    chk({tag, "_addr"}, arb2dcache_addr, 32'h0);
    chk({tag, "_wdata"}, arb2dcache_wdata, 32'h0);
    chk({tag, "_sel"}, arb2dcache_sel_byte, 4'h0);
    chk({tag, "_w_en"}, arb2dcache_w_en, 1'b0);
    chk({tag, "_dmem"}, arb2dcache_dmem_sel, 1'b0);
    chk({tag, "_stb_ack"}, arb2stb_ack, 1'b0);
    chk({tag, "_lsu_ack"}, arb2lsu_ack, 1'b0);
    chk({tag, "_rdata"}, arb2lsu_rdata, 32'h0);
  endtask

  vec_t vecs[6];
  bit   starve_exp[6];

  initial begin
    vecs[0] = '{1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 0, 32'h0,   4'h0, 2, 32'h0,        1, 1};
    vecs[1] = '{1, 32'h100, 32'hA5A5A5A5, 4'hF, 1'b0, 1, 32'h200, 4'hF, 0, 32'h12345678, 0, 2};
    vecs[2] = '{1, 32'h100, 32'h0BADF00D, 4'h3, 1'b0, 1, 32'h102, 4'hC, 1, 32'h55AA55AA, 1, 2};
    vecs[3] = '{1, 32'h300, 32'h13579BDF, 4'hF, 1'b1, 1, 32'h400, 4'hF, 0, 32'h2468ACE0, 1, 2};
    vecs[4] = '{0, 32'h0,   32'h0,        4'h0, 1'b0, 1, 32'h040, 4'h1, 3, 32'hFEEDFACE, 0, 1};
    vecs[5] = '{1, 32'h100, 32'h11112222, 4'h8, 1'b0, 1, 32'h104, 4'h2, 1, 32'h33334444, 0, 2};
`ifdef ARB_STARVE_GUARD_EN
    starve_exp = '{0, 0, 0, 0, 1, 0};
`else
    starve_exp = '{0, 0, 0, 0, 0, 1};
`endif

    rst_n = 1'b0;
    stb2arb_addr = '0; stb2arb_wdata = '0; stb2arb_sel_byte = '0;
    stb2arb_req = 1'b0; stb2arb_full = 1'b0; stb2arb_dmem_sel = 1'b0;
    lsu2arb_addr = '0; lsu2arb_sel_byte = '0; lsu2arb_req = 1'b0; lsu2arb_dmem_sel = 1'b0;
    dcache2arb_rdata = '0; dcache2arb_ack = 1'b0;
    m_phase = 0; m_starve = 0; dc_delay = 0; dc_cnt = 0;
    fixed_rdata_en = 1'b0; fixed_rdata = '0; exp_rdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // directed vectors
    for (int v = 0; v < 6; v++) begin
      grant_log.delete();
      if (vecs[v].s_v) st_q.push_back('{vecs[v].s_addr, vecs[v].s_wdata, vecs[v].s_sel, vecs[v].s_full, 1'b1});
      if (vecs[v].l_v) ld_q.push_back('{vecs[v].l_addr, vecs[v].l_sel, 1'b1});
      dc_delay       = vecs[v].delay;
      fixed_rdata_en = 1'b1;
      fixed_rdata    = vecs[v].rdata;
      run_engine(100);
      chk($sformatf("vec%0d_n_grants", v), grant_log.size(), vecs[v].exp_n);
      if (grant_log.size() > 0) chk($sformatf("vec%0d_first_owner", v), grant_log[0], vecs[v].exp_first_store);
    end

    // starvation: one waiting store against five back-to-back loads
    grant_log.delete();
    st_q.push_back('{32'h500, 32'h77778888, 4'hF, 1'b0, 1'b1});
    for (int i = 0; i < 5; i++) ld_q.push_back('{32'(32'h600 + 4 * i), 4'hF, 1'b1});
    dc_delay = 0;
    fixed_rdata_en = 1'b0;
    run_engine(200);
    chk("starve_n_grants", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("starve_order%0d", i), grant_log[i], starve_exp[i]);

    // randomized scenarios against the reference model
    for (int r = 0; r < 40; r++) begin
      int ns, nl;
      ns = $urandom_range(0, 3);
      nl = $urandom_range(0, 3);
      for (int i = 0; i < ns; i++)
        st_q.push_back('{32'(32'h100 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3)), $urandom,
                         4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
      for (int i = 0; i < nl; i++)
        ld_q.push_back('{32'(32'h100 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3)),
                         4'($urandom_range(1, 15)), 1'($urandom_range(0, 1))});
      dc_delay = $urandom_range(0, 3);
      run_engine(200);
    end

    // reset while a store is in flight
    grant_log.delete();
    st_q.push_back('{32'h700, 32'hCAFEF00D, 4'h3, 1'b0, 1'b1});
    drive_inputs();
    @(posedge clk);
    #1;
    chk("rst_seq_grant_req", arb2dcache_req, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("busy_reset");
    @(posedge clk);
    #1;
    chk("busy_reset_no_stb_ack", arb2stb_ack, 1'b0);
    rst_n = 1'b1;
    m_phase = 0; m_starve = 0; dcache2arb_ack = 1'b0; dc_delay = 1;
    run_engine(50);
    chk("post_reset_n_grants", grant_log.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ack exclusivity, sampled on the falling edge
  always @(negedge clk) begin
    if (arb2stb_ack && arb2lsu_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_exclusive at %0t: stb_ack=1 lsu_ack=1, required not both", $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stb_dcache_arbiter.md
Name: stb_dcache_arbiter

Overview:
- Sits directly downstream of the store buffer and in front of the dcache's single request port.
- Arbitrates store-buffer drain writes against LSU load reads and drives one registered request at a time to the dcache.
- Returns the dcache acknowledge to the request's owner, plus read data for loads.
- Loads normally bypass buffered stores. A full store buffer or a load hitting the head store's word address forces the store first.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BYTE_SEL_WIDTH, 4, byte-select width
STARVE_MAX, 4, consecutive load grants tolerated while a store waits (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset
stb2arb_addr  in  ADDR_WIDTH  head store address
stb2arb_wdata  in  DATA_WIDTH  head store data
stb2arb_sel_byte  in  BYTE_SEL_WIDTH  head store byte select
stb2arb_req  in  1  store request
stb2arb_full  in  1  store buffer full
stb2arb_dmem_sel  in  1  data-memory select for the store
arb2stb_ack  out  1  store accepted by dcache
lsu2arb_addr  in  ADDR_WIDTH  load address
lsu2arb_sel_byte  in  BYTE_SEL_WIDTH  load byte select
lsu2arb_req  in  1  load request
lsu2arb_dmem_sel  in  1  data-memory select for the load
arb2lsu_rdata  out  DATA_WIDTH  load data
arb2lsu_ack  out  1  load complete
arb2dcache_addr  out  ADDR_WIDTH  request address
arb2dcache_wdata  out  DATA_WIDTH  write data
arb2dcache_sel_byte  out  BYTE_SEL_WIDTH  byte select
arb2dcache_w_en  out  1  1=write, 0=read
arb2dcache_req  out  1  request valid
arb2dcache_dmem_sel  out  1  data-memory select
dcache2arb_rdata  in  DATA_WIDTH  read data
dcache2arb_ack  in  1  transaction done

Behaviour:
- Reset: rst_n is synchronous, active-low. Reset forces IDLE and zeroes every output and the internal counter. A reset during BUSY abandons the in-flight transaction.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Samples requests on each edge.
  - If any request is present: register the winner's fields onto the arb2dcache_* outputs, set arb2dcache_req=1, record the owner, go to BUSY.
  - Request-to-dcache latency is 1 cycle.
- Winner selection, in priority order:
  1. Only one request present: that one.
  2. stb2arb_full=1: store.
  3. Load word address (addr[ADDR_WIDTH-1:2]) equals store word address: store.
  4. Otherwise: load.
  - Store order is preserved because only the head store is ever presented.
  - Forwarding from deeper buffer entries is not this block's job.
- BUSY:
  - All arb2dcache_* outputs are held stable.
  - On dcache2arb_ack=1: drop arb2dcache_req, capture dcache2arb_rdata for a load, go to RESP.
  - Requests arriving during BUSY wait; they are not lost, because requesters hold req.
- RESP:
  - Pulse the owner's ack for exactly 1 cycle; arb2lsu_rdata is valid in that cycle.
  - Next state is IDLE.
  - Requests are ignored in RESP.
- Requester contract: hold req and all fields stable until ack is seen, then deassert req from the following edge. A back-to-back request may be asserted from that same edge.
- Throughput: minimum 3 cycles per transaction (IDLE, BUSY with immediate ack, RESP).
- Read-data output: arb2lsu_rdata holds its last value outside RESP. It is zero after reset.
- Ack exclusivity: arb2stb_ack and arb2lsu_ack are never high together.
- Simultaneous requests in IDLE: resolved by the priority above. The loser is granted on the next IDLE.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter (width clog2(STARVE_MAX+1)) increments on each load grant made while stb2arb_req=1.
  - It clears on any store grant and whenever stb2arb_req=0 in IDLE.
  - When the counter equals STARVE_MAX, the store wins regardless of the other rules.
- Not defined: the counter is absent and only the priority rules above apply, so stores can starve until the buffer fills.

Decomposition:
- Shared package arb_pkg:
  - state enum arb_state_e {IDLE, BUSY, RESP}
  - owner enum arb_owner_e {OWN_LOAD, OWN_STORE}
  - WORD_OFFSET=2
- One natural sub-module, arb_grant_sel: purely combinational winner selection, including the address compare and starvation input.
- The FSM and output registers stay in the top.

Test Plan:
- Store only: stb req addr=0x100, wdata=0xDEADBEEF, sel=0xF; dcache acks 2 cycles after req -> dcache sees req/w_en=1 with the same fields; arb2stb_ack pulses exactly once, in the cycle after the dcache ack.
- Simultaneous requests: load addr=0x200 and store addr=0x100, full=0 -> load granted first and rdata=0x12345678 returned with arb2lsu_ack; store is granted on the next IDLE.
- Address match: load addr=0x102 and store addr=0x100 -> store is served first, then the load.
- Full override: store addr=0x300 with full=1, load addr=0x400 pending -> store granted first.
- Starvation (macro on, STARVE_MAX=4): store pending, 5 back-to-back loads -> grant order L,L,L,L,S,L. Macro off: all loads are served before the store.
- Reset: assert rst_n=0 in BUSY -> next edge: state IDLE, all outputs 0, no ack pulse; after release a new store completes normally.
